// File: rtl/dm9000a_bus_sched.sv
// DM9000A host-bus scheduler: round-robin arbitration of two requesters into
// index + data bus cycles with programmable timing. Optional index cache: DM9000A_IDX_CACHE_EN.
module dm9000a_bus_sched #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [15:0] req_reg,
  input  logic [31:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        enet_cs_n,
  output logic        enet_cmd,
  output logic        enet_ior_n,
  output logic        enet_iow_n,
  output logic [15:0] enet_data_out,
  output logic        enet_data_oe,
  input  logic [15:0] enet_data_in
);

  localparam int CW = 8;
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, IDX_SETUP, IDX_STROBE, IDX_HOLD, DAT_SETUP, DAT_STROBE, DAT_HOLD, DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            last_grant;
  logic            grant, accept, idx_hit;
  logic [7:0]      sel_reg;
  logic [15:0]     sel_wdata;
  logic            sel_write;

  logic [7:0]      reg_q;
  logic [15:0]     wdata_q;
  logic            write_q;
  logic            gnt_q;
  logic            cap_en;
  logic [15:0]     rdata_cap;

  logic            cs_n_d, cmd_d, ior_n_d, iow_n_d, oe_d;
  logic [15:0]     dout_d;
  logic [1:0]      rsp_valid_d;

  // With both requesters pending, the one not served last wins.
  always_comb begin
    grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    sel_reg   = grant ? req_reg[15:8]    : req_reg[7:0];
    sel_wdata = grant ? req_wdata[31:16] : req_wdata[15:0];
    sel_write = grant ? req_write[1]     : req_write[0];
    accept    = (state == IDLE) && (req_valid != 2'b00);
  end

`ifdef DM9000A_IDX_CACHE_EN
  logic       cache_valid;
  logic [7:0] cache_idx;

  assign idx_hit = cache_valid && (cache_idx == sel_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_idx   <= '0;
    end else if (state == IDX_HOLD && cnt == '0) begin
      cache_valid <= 1'b1;
      cache_idx   <= reg_q;
    end
  end
`else
  assign idx_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state: one down-counter, reloaded with the length of each phase on entry
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would infer a latch.
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - 1'b1 : cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = idx_hit ? DAT_SETUP : IDX_SETUP;
          cnt_n   = SETUP_LD;
        end
      end
      IDX_SETUP:  if (cnt == '0) begin state_n = IDX_STROBE; cnt_n = STROBE_LD; end
      IDX_STROBE: if (cnt == '0) begin state_n = IDX_HOLD;   cnt_n = HOLD_LD;   end
      IDX_HOLD:   if (cnt == '0) begin state_n = DAT_SETUP;  cnt_n = SETUP_LD;  end
      DAT_SETUP:  if (cnt == '0) begin state_n = DAT_STROBE; cnt_n = STROBE_LD; end
      DAT_STROBE: if (cnt == '0) begin state_n = DAT_HOLD;   cnt_n = HOLD_LD;   end
      DAT_HOLD:   if (cnt == '0) begin state_n = DONE;       cnt_n = '0;        end
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // Bus drive values for the current state; registered one cycle later
  always_comb begin
    cs_n_d      = 1'b1;
    cmd_d       = 1'b0;
    ior_n_d     = 1'b1;
    iow_n_d     = 1'b1;
    oe_d        = 1'b0;
    dout_d      = '0;
    rsp_valid_d = 2'b00;
    case (state)
      IDX_SETUP, IDX_STROBE, IDX_HOLD: begin
        // CS_n drops out for the final hold cycle to separate index and data cycles
        cs_n_d  = (state == IDX_HOLD) && (cnt == '0);
        oe_d    = 1'b1;
        dout_d  = {8'h00, reg_q};
        iow_n_d = (state != IDX_STROBE);
      end
      DAT_SETUP, DAT_STROBE, DAT_HOLD: begin
        cs_n_d  = 1'b0;
        cmd_d   = 1'b1;
        oe_d    = write_q;
        dout_d  = write_q ? wdata_q : 16'h0000;
        iow_n_d = !((state == DAT_STROBE) && write_q);
        ior_n_d = !((state == DAT_STROBE) && !write_q);
      end
      DONE:    rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  // Request latch and arbitration history
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      req_ready  <= 2'b00;
      gnt_q      <= 1'b0;
      write_q    <= 1'b0;
      cap_en     <= 1'b0;
    end else begin
      req_ready <= accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
      if (accept) begin
        last_grant <= grant;
        gnt_q      <= grant;
        write_q    <= sel_write;
      end
      // Flags the cycle in which the bus shows the last read-strobe cycle
      cap_en <= (state == DAT_STROBE) && (cnt == '0) && !write_q;
    end
  end

  // NOTE: pure data registers carry no reset; they are always loaded before
  // any control path consumes them.
  always_ff @(posedge clk) begin
    if (accept) begin
      reg_q   <= sel_reg;
      wdata_q <= sel_wdata;
    end
    if (cap_en) rdata_cap <= enet_data_in;
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      enet_cs_n     <= 1'b1;
      enet_cmd      <= 1'b0;
      enet_ior_n    <= 1'b1;
      enet_iow_n    <= 1'b1;
      enet_data_oe  <= 1'b0;
      enet_data_out <= '0;
      rsp_valid     <= 2'b00;
      rsp_rdata     <= '0;
    end else begin
      enet_cs_n     <= cs_n_d;
      enet_cmd      <= cmd_d;
      enet_ior_n    <= ior_n_d;
      enet_iow_n    <= iow_n_d;
      enet_data_oe  <= oe_d;
      enet_data_out <= dout_d;
      rsp_valid     <= rsp_valid_d;
      if (state == DONE && !write_q) rsp_rdata <= rdata_cap;
    end
  end

endmodule

// File: tb/tb_dm9000a_bus_sched.sv
// Scoreboard bench for dm9000a_bus_sched: expected accesses are queued by the
// stimulus; one monitor checks grants, bus timing and responses.
`timescale 1ns/1ps
module tb_dm9000a_bus_sched;

  localparam int S = 2, P = 3, H = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [15:0] req_reg, rsp_rdata, data_out, data_in;
  logic [31:0] req_wdata;
  logic        cs_n, cmd, ior_n, iow_n, oe;

  logic [1:0]  f_req_valid, f_req_write, f_req_ready, f_rsp_valid;
  logic [15:0] f_req_reg, f_rsp_rdata, f_data_out, f_data_in;
  logic [31:0] f_req_wdata;
  logic        f_cs_n, f_cmd, f_ior_n, f_iow_n, f_oe;

  always #5 clk = ~clk;

  dm9000a_bus_sched #(.SETUP_CYC(S), .STROBE_CYC(P), .HOLD_CYC(H)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_reg(req_reg), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .enet_cs_n(cs_n),
    .enet_cmd(cmd), .enet_ior_n(ior_n), .enet_iow_n(iow_n),
    .enet_data_out(data_out), .enet_data_oe(oe), .enet_data_in(data_in));

  dm9000a_bus_sched #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_f (
    .clk(clk), .rst(rst), .req_valid(f_req_valid), .req_write(f_req_write),
    .req_reg(f_req_reg), .req_wdata(f_req_wdata), .req_ready(f_req_ready),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .enet_cs_n(f_cs_n),
    .enet_cmd(f_cmd), .enet_ior_n(f_ior_n), .enet_iow_n(f_iow_n),
    .enet_data_out(f_data_out), .enet_data_oe(f_oe), .enet_data_in(f_data_in));

  typedef struct {
    int          id;
    bit          write;
    logic [7:0]  rg;
    logic [15:0] wd;
    logic [15:0] rd;
    bit          hit;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  bit          active;
  int          t_acc;
  int          cyc;
  int          n_checks, n_fail;
  logic [15:0] chip_rd, f_chip_rd;
  bit          mc_v;
  logic [7:0]  mc;

  always @(posedge clk) cyc = cyc + 1;

  // Chip model: read data is only valid while the read strobe is low
  always @(negedge clk) begin
    data_in   = !ior_n   ? chip_rd   : 16'hDEAD;
    f_data_in = !f_ior_n ? f_chip_rd : 16'hDEAD;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: grant order, per-cycle bus timing, response id/latency/data
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != 2'b00) begin
        if (exp_q.size() == 0) check("unexpected_ready", {30'd0, req_ready}, 32'd0);
        else begin
          cur = exp_q.pop_front();
          check("grant_id", {30'd0, req_ready}, 32'(2'b01 << cur.id));
          active = 1'b1;
          t_acc  = cyc;
        end
      end else if (active) begin
        int off, d0, lat;
        bit in_is, in_ds, in_dp;
        off   = cyc - t_acc;
        d0    = cur.hit ? 0 : S + P + H;
        lat   = d0 + S + P + H + 1;
        in_is = !cur.hit && off >= 1 + S && off <= S + P;
        in_ds = off >= d0 + 1 + S && off <= d0 + S + P;
        in_dp = off >= d0 + 1 && off <= d0 + S + P + H;
        check("iow_n", {31'd0, iow_n}, {31'd0, !(in_is || (cur.write && in_ds))});
        check("ior_n", {31'd0, ior_n}, {31'd0, !(!cur.write && in_ds)});
        if (in_is) check("idx_bus", {13'd0, cs_n, cmd, oe, data_out}, {13'd0, 3'b001, 8'h00, cur.rg});
        if (in_dp) begin
          check("dat_ctl", {29'd0, cs_n, cmd, oe}, {29'd0, 2'b01, cur.write});
          if (cur.write) check("dat_wdata", {16'd0, data_out}, {16'd0, cur.wd});
        end
        if (!cur.hit && off == S + P + H) check("cs_gap", {31'd0, cs_n}, 32'd1);
        if (rsp_valid != 2'b00) begin
          check("rsp_id", {30'd0, rsp_valid}, 32'(2'b01 << cur.id));
          check("rsp_latency", off, lat);
          if (!cur.write) check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, cur.rd});
          active = 1'b0;
        end else if (off > lat) begin
          check("rsp_timeout", off, lat);
          active = 1'b0;
        end
      end else if (rsp_valid != 2'b00) begin
        check("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
      end
    end
  end

  task automatic push(input int id, input bit wr, input logic [7:0] rg,
                      input logic [15:0] wd, input logic [15:0] rd);
    exp_t e;
    e.id = id; e.write = wr; e.rg = rg; e.wd = wd; e.rd = rd;
`ifdef DM9000A_IDX_CACHE_EN
    e.hit = mc_v && (mc == rg);
    mc    = rg;
    mc_v  = 1'b1;
`else
    e.hit = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic drive(input int id, input bit wr, input logic [7:0] rg, input logic [15:0] wd);
    req_write[id]       = wr;
    req_reg[id*8 +: 8]  = rg;
    req_wdata[id*16 +: 16] = wd;
    req_valid[id]       = 1'b1;
  endtask

  task automatic wait_ready(input int id);
    int n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[id] && n < 100);
    if (!req_ready[id]) check("ready_timeout", {31'd0, req_ready[id]}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((active || exp_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
    check("idle_timeout", {31'd0, active || exp_q.size() != 0}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    active = 1'b0;
    exp_q.delete();
    mc_v   = 1'b0;
    repeat (n) @(negedge clk);
    rst    = 1'b0;
  endtask

  initial begin
    logic [1:0] seen;
    int         got, n, t0;
    req_valid = '0; req_write = '0; req_reg = '0; req_wdata = '0;
    f_req_valid = '0; f_req_write = '0; f_req_reg = '0; f_req_wdata = '0;
    chip_rd = 16'h0000; f_chip_rd = 16'h0000; data_in = 16'hDEAD; f_data_in = 16'hDEAD;
    n_checks = 0; n_fail = 0; cyc = 0; active = 1'b0; mc_v = 1'b0; mc = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctl", {27'd0, cs_n, ior_n, iow_n, cmd, oe}, {27'd0, 5'b11100});
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    check("rst_handshake", {28'd0, req_ready, rsp_valid}, 32'd0);
    check("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single write from requester 0
    push(0, 1'b1, 8'h1F, 16'h0000, 16'h0);
    drive(0, 1'b1, 8'h1F, 16'h0000);
    wait_ready(0); req_valid[0] = 1'b0;
    wait_idle();

    // Single read from requester 1
    chip_rd = 16'h0A46;
    push(1, 1'b0, 8'h28, 16'h0000, 16'h0A46);
    drive(1, 1'b0, 8'h28, 16'h0000);
    wait_ready(1); req_valid[1] = 1'b0;
    wait_idle();

    // Both requesters held: strict alternation 0,1,0,1
    push(0, 1'b1, 8'h02, 16'h1111, 16'h0);
    push(1, 1'b1, 8'h03, 16'h2222, 16'h0);
    push(0, 1'b1, 8'h02, 16'h1111, 16'h0);
    push(1, 1'b1, 8'h03, 16'h2222, 16'h0);
    drive(0, 1'b1, 8'h02, 16'h1111);
    drive(1, 1'b1, 8'h03, 16'h2222);
    got = 0; n = 0;
    while (got < 4 && n < 200) begin
      @(negedge clk); n++;
      if (req_ready != 2'b00) got++;
    end
    check("alternation_accepts", got, 4);
    req_valid = 2'b00;
    wait_idle();

    // Reset during the data strobe of a requester-0 write
    push(0, 1'b1, 8'h05, 16'hBEEF, 16'h0);
    drive(0, 1'b1, 8'h05, 16'hBEEF);
    wait_ready(0); req_valid[0] = 1'b0;
    repeat (S + P + H + 1 + S) @(negedge clk);
    check("pre_abort_iow", {31'd0, iow_n}, 32'd0);
    rst = 1'b1; active = 1'b0; exp_q.delete(); mc_v = 1'b0;
    @(negedge clk);
    check("abort_bus", {29'd0, cs_n, iow_n, oe}, {29'd0, 3'b110});
    rst = 1'b0;
    seen = 2'b00;
    repeat (20) begin @(negedge clk); seen |= rsp_valid; end
    check("aborted_rsp", {30'd0, seen}, 32'd0);
    push(0, 1'b1, 8'h06, 16'h0606, 16'h0);
    push(1, 1'b1, 8'h07, 16'h0707, 16'h0);
    drive(0, 1'b1, 8'h06, 16'h0606);
    drive(1, 1'b1, 8'h07, 16'h0707);
    wait_ready(0); req_valid[0] = 1'b0;
    wait_ready(1); req_valid[1] = 1'b0;
    wait_idle();

    // Repeated MWCMD writes; second skips the index phase when the cache is built in
    push(0, 1'b1, 8'hF8, 16'hA001, 16'h0);
    drive(0, 1'b1, 8'hF8, 16'hA001);
    wait_ready(0); req_valid[0] = 1'b0;
    wait_idle();
    push(0, 1'b1, 8'hF8, 16'hA002, 16'h0);
    drive(0, 1'b1, 8'hF8, 16'hA002);
    wait_ready(0); req_valid[0] = 1'b0;
    wait_idle();
    do_reset(2);
    @(negedge clk);
    push(0, 1'b1, 8'hF8, 16'hA003, 16'h0);
    drive(0, 1'b1, 8'hF8, 16'hA003);
    wait_ready(0); req_valid[0] = 1'b0;
    wait_idle();

    // Minimum timing instance: read completes at T+7 with correct capture
    f_chip_rd = 16'h5A3C;
    f_req_write[0] = 1'b0; f_req_reg[7:0] = 8'h10; f_req_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!f_req_ready[0] && n < 50);
    check("fast_ready", {31'd0, f_req_ready[0]}, 32'd1);
    t0 = cyc;
    f_req_valid[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (f_rsp_valid == 2'b00 && n < 30);
    check("fast_rsp_id", {30'd0, f_rsp_valid}, 32'd1);
    check("fast_latency", cyc - t0, 7);
    check("fast_rdata", {16'd0, f_rsp_rdata}, {16'd0, 16'h5A3C});

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm9000a_bus_sched.md
Name: dm9000a_bus_sched

Overview:
- Schedules and sequences all register accesses to the external DM9000A Ethernet controller.
- Two internal requesters share the chip's single 16-bit host bus: requester 0 is MAC/PHY config and init, requester 1 is the UDP TX/RX datapath.
- Each request becomes a DM9000A index cycle (CMD=Index, write register address) followed by a data cycle (CMD=Data, read or write 16 bits), with programmable strobe timing.
- Requesters are arbitrated round-robin.

Parameters:
- SETUP_CYC, 2, cycles CS_n/CMD/data are valid before the IOR_n/IOW_n strobe (min 1)
- STROBE_CYC, 3, cycles the strobe is held low (min 1)
- HOLD_CYC, 2, cycles CS_n/CMD/data are held after the strobe rises (min 1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester access request, level
- req_write  in  2  per requester: 1=write, 0=read
- req_reg  in  16  {req1[15:8], req0[7:0]} DM9000A register index
- req_wdata  in  32  {req1[31:16], req0[15:0]} write data
- req_ready  out  2  one-cycle pulse: request accepted, inputs sampled
- rsp_valid  out  2  one-cycle pulse: access complete
- rsp_rdata  out  16  read data, valid with rsp_valid (shared)
- enet_cs_n  out  1  chip select, active low
- enet_cmd  out  1  0=Index, 1=Data
- enet_ior_n  out  1  read strobe, active low
- enet_iow_n  out  1  write strobe, active low
- enet_data_out  out  16  bus drive value
- enet_data_oe  out  1  1 = drive the bus
- enet_data_in  in  16  bus sample value

Behaviour:
- Clocking and reset: one clock, all outputs registered. Reset is synchronous and active-high.
- Reset values: enet_cs_n=1, enet_ior_n=1, enet_iow_n=1, enet_cmd=0, enet_data_oe=0, enet_data_out=0, req_ready=0, rsp_valid=0, rsp_rdata=0, last_grant=1, FSM=IDLE.
- FSM states: IDLE, IDX_SETUP, IDX_STROBE, IDX_HOLD, DAT_SETUP, DAT_STROBE, DAT_HOLD, DONE.
- IDLE:
  - If any req_valid is set, grant the requester that is not last_grant; if only one is valid, grant it.
  - Pulse req_ready[g], latch reg/wdata/write/g, update last_grant, go to IDX_SETUP.
  - No acceptance in any other state.
- Phase lengths: each *_SETUP/*_STROBE/*_HOLD state lasts SETUP_CYC/STROBE_CYC/HOLD_CYC cycles, counted by one down-counter reloaded on state entry.
- Index phase:
  - cs_n=0, cmd=0, oe=1, data_out={8'h00, reg}.
  - iow_n=0 only in IDX_STROBE.
- Data phase:
  - cs_n=0, cmd=1.
  - Write: oe=1, data_out=wdata, iow_n=0 in DAT_STROBE.
  - Read: oe=0, ior_n=0 in DAT_STROBE; enet_data_in is captured into rsp_rdata on the last DAT_STROBE cycle.
- Between phases: cs_n is deasserted for the last cycle of IDX_HOLD. oe never changes while a strobe is low.
- DONE: all bus controls inactive, rsp_valid[g] pulses for 1 cycle, then IDLE.
  - rsp_rdata holds its value until the next read completes.
  - Write completions leave rsp_rdata unchanged.
- Latency with defaults, accept at cycle T:
  - Index phase T+1..T+7, data phase T+8..T+14, rsp_valid at T+15.
  - Next accept no earlier than T+16.
- Simultaneous requests: strict alternation. A single persistent requester is served back-to-back.
- Request deasserted after acceptance: the access completes regardless.
- rst mid-access: all strobes and CS_n return inactive on the next edge. No rsp_valid for the aborted access. last_grant returns to 1.

Optional Feature:
- Macro: DM9000A_IDX_CACHE_EN.
- Defined:
  - A register holds the last index written plus a valid bit; valid is cleared by rst.
  - An accepted request whose reg equals the cached index goes IDLE->DAT_SETUP, skipping the index phase. This enables MWCMD/MRCMD burst streaming.
  - With defaults, rsp_valid arrives at T+8.
  - Every completed index phase updates the cache.
- Undefined: every access performs the index phase.

Test Plan:
- Write, req0 only, reg=8'h1F, wdata=16'h0000, accept at T:
  - cmd=0, data_out=16'h001F, iow_n low T+3..T+5.
  - cmd=1, data_out=16'h0000, iow_n low T+10..T+12.
  - rsp_valid[0] at T+15.
- Read, req1, reg=8'h28, enet_data_in=16'h0A46:
  - ior_n low T+10..T+12, oe=0 throughout the data phase.
  - rsp_rdata=16'h0A46 with rsp_valid[1] at T+15.
- Both requesters held valid for 4 accesses after reset:
  - Grant order 0,1,0,1.
  - Each req_ready pulse precedes the corresponding rsp_valid by 15 cycles.
- rst asserted during DAT_STROBE of a write:
  - Next cycle cs_n=1, iow_n=1, oe=0.
  - No rsp_valid.
  - The following request is granted to req0.
- With DM9000A_IDX_CACHE_EN, two writes to reg=8'hF8 (MWCMD):
  - Second write has no cmd=0 cycle and rsp_valid at T+8.
  - After rst, the first write again performs the index phase.
- SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1: read completes with rsp_valid at T+7 and correct data capture.
